// File: rtl/mcycle_controller.sv
// Multi-cycle MIPS control FSM: IF/ID/EX/MEM/WB sequencing with combinational control outputs.
// Define MCTRL_MEM_WAIT_EN to stall IF and MEM until MemReady is high.
//
// state | meaning
// IF    | fetch instruction, PC += 4
// ID    | decode, branch target calc, jumps resolve here
// EX    | ALU execute, beq resolves here
// MEM   | data memory access for lw/sw
// WB    | register file write-back
module mcycle_controller #(
    parameter int ALU_OP_W = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [5:0]          OpCode,
    input  logic [5:0]          Funct,
    input  logic                MemReady,
    output logic                PCWrite,
    output logic                PCWriteCond,
    output logic                IorD,
    output logic                MemRead,
    output logic                MemWrite,
    output logic                IRWrite,
    output logic                RegWrite,
    output logic                ExtOp,
    output logic                LuiOp,
    output logic [1:0]          RegDst,
    output logic [1:0]          MemtoReg,
    output logic [1:0]          ALUSrcA,
    output logic [1:0]          ALUSrcB,
    output logic [1:0]          PCSource,
    output logic [ALU_OP_W-1:0] ALUOp,
    output logic [2:0]          State
);

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EX  = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_t;

    state_t state_q, state_d;
    logic   mem_ok;
    logic   is_rtype, is_jr, is_j, is_jal, is_beq, is_lw, is_sw;
    logic   is_addi, is_andi, is_ori, is_slti, is_lui, is_arith;
    logic [2:0] alu_class;

`ifdef MCTRL_MEM_WAIT_EN
    assign mem_ok = MemReady;
`else
    logic unused_memready;
    assign unused_memready = MemReady;
    assign mem_ok = 1'b1;
`endif

    assign is_rtype = (OpCode == 6'h00) && (Funct != 6'h08);
    assign is_jr    = (OpCode == 6'h00) && (Funct == 6'h08);
    assign is_j     = (OpCode == 6'h02);
    assign is_jal   = (OpCode == 6'h03);
    assign is_beq   = (OpCode == 6'h04);
    assign is_addi  = (OpCode == 6'h08);
    assign is_slti  = (OpCode == 6'h0a);
    assign is_andi  = (OpCode == 6'h0c);
    assign is_ori   = (OpCode == 6'h0d);
    assign is_lui   = (OpCode == 6'h0f);
    assign is_lw    = (OpCode == 6'h23);
    assign is_sw    = (OpCode == 6'h2b);
    assign is_arith = is_rtype | is_addi | is_andi | is_ori | is_slti | is_lui;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_IF;
        else        state_q <= state_d;
    end

    assign State = state_q;

    always_comb begin
        alu_class = 3'd0;
        case (OpCode)
            6'h04:   alu_class = 3'd1;
            6'h00:   alu_class = 3'd2;
            6'h0c:   alu_class = 3'd3;
            6'h0d:   alu_class = 3'd4;
            6'h0a:   alu_class = 3'd5;
            default: alu_class = 3'd0;
        endcase
    end

    assign ALUOp = ALU_OP_W'(alu_class);

    always_comb begin
        state_d     = state_q;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        RegWrite    = 1'b0;
        ExtOp       = 1'b0;
        LuiOp       = 1'b0;
        RegDst      = 2'b00;
        MemtoReg    = 2'b00;
        ALUSrcA     = 2'b00;
        ALUSrcB     = 2'b00;
        PCSource    = 2'b00;
        case (state_q)
            S_IF: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                if (mem_ok) begin
                    PCWrite = 1'b1;
                    IRWrite = 1'b1;
                    state_d = S_ID;
                end
            end
            S_ID: begin
                ALUSrcB = 2'b11;
                if (is_j || is_jal) begin
                    PCWrite  = 1'b1;
                    PCSource = 2'b10;
                end
                if (is_jal) begin
                    RegWrite = 1'b1;
                    RegDst   = 2'b10;
                    MemtoReg = 2'b10;
                end
                if (is_jr) begin
                    PCWrite  = 1'b1;
                    PCSource = 2'b11;
                end
                // unrecognised opcodes fall back to IF as a NOP
                state_d = (is_arith || is_beq || is_lw || is_sw) ? S_EX : S_IF;
            end
            S_EX: begin
                ALUSrcA = 2'b01;
                ALUSrcB = (is_rtype || is_beq) ? 2'b00 : 2'b10;
                ExtOp   = !(is_andi || is_ori);
                LuiOp   = is_lui;
                if (is_beq) begin
                    PCWriteCond = 1'b1;
                    PCSource    = 2'b01;
                end
                if (is_lw || is_sw) state_d = S_MEM;
                else if (is_arith)  state_d = S_WB;
                else                state_d = S_IF;
            end
            S_MEM: begin
                IorD     = 1'b1;
                MemRead  = is_lw;
                MemWrite = is_sw;
                if (mem_ok) state_d = is_lw ? S_WB : S_IF;
            end
            S_WB: begin
                RegWrite = 1'b1;
                RegDst   = is_rtype ? 2'b01 : 2'b00;
                MemtoReg = is_lw ? 2'b01 : 2'b00;
                state_d  = S_IF;
            end
            default: state_d = S_IF;
        endcase
        // reset kills writes combinationally so an abort never leaks a partial write
        if (!reset) begin
            PCWrite     = 1'b0;
            PCWriteCond = 1'b0;
            MemWrite    = 1'b0;
            IRWrite     = 1'b0;
            RegWrite    = 1'b0;
        end
    end

endmodule

// File: doc/mcycle_controller.md
MCYCLE_CONTROLLER -- requirements
Module: mcycle_controller

Interface
REQ-001 SHALL have one clock; reset is asynchronous and active-low.
REQ-002 Parameter: ALU_OP_W, default 4, width of ALUOp.
REQ-003 SHALL have port: clk  input  1  rising-edge clock.
REQ-004 SHALL have port: reset  input  1  asynchronous reset, active-low (0 = reset).
REQ-005 SHALL have port: OpCode  input  6  opcode from the instruction register.
REQ-006 SHALL have port: Funct  input  6  funct field from the instruction register.
REQ-007 SHALL have port: MemReady  input  1  memory data valid; used only when MCTRL_MEM_WAIT_EN is defined.
REQ-008 SHALL have outputs, each 1 bit: PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite, ExtOp, LuiOp.
REQ-009 SHALL have outputs, each 2 bits: RegDst, MemtoReg, ALUSrcA, ALUSrcB, PCSource.
REQ-010 SHALL have outputs: ALUOp  output  ALU_OP_W  ALU operation class; State  output  3  current state, for debug.

Function
REQ-011 SHALL hold a 3-bit state register with the following encoding: IF=0, ID=1, EX=2, MEM=3, WB=4; codes 5-7 are illegal.
REQ-012 SHALL leave IF for ID unconditionally.
REQ-013 SHALL make the following transitions from ID:
- j (0x02), jal (0x03) and jr (OpCode 0, Funct 0x08) go to IF.
- Unrecognised opcodes go to IF and act as a NOP with no writes.
- All other instructions go to EX.
REQ-014 SHALL make the following transitions from EX:
- beq (0x04) goes to IF.
- lw (0x23) and sw (0x2b) go to MEM.
- R-type, addi (0x08), andi (0x0c), ori (0x0d), slti (0x0a) and lui (0x0f) go to WB.
REQ-015 SHALL make the following transitions from MEM: lw goes to WB; sw goes to IF.
REQ-016 SHALL make WB go to IF.
REQ-017 SHALL force any illegal state code to IF on the next edge, with all write enables 0 while in that state.
REQ-018 SHALL have these latencies in cycles, from IF entry to the next IF entry: j/jal/jr 2, beq 3, R/I-arith 4, sw 4, lw 5.
REQ-019 SHALL drive these IF outputs: MemRead=1, IorD=0, IRWrite=1, ALUSrcA=0, ALUSrcB=01 (+4), PCSource=00, PCWrite=1.
REQ-020 SHALL drive these ID outputs:
- Branch target is computed with ALUSrcA=0, ALUSrcB=11.
- j/jal: PCWrite=1, PCSource=10.
- jal: RegWrite=1, RegDst=10 ($31), MemtoReg=10 (PC).
- jr: PCWrite=1, PCSource=11.
REQ-021 SHALL drive these EX outputs:
- ALUSrcA=1.
- ALUSrcB=00 for R-type/beq, 10 otherwise.
- beq: PCWriteCond=1, PCSource=01.
- ExtOp=0 for andi/ori, 1 otherwise.
- LuiOp=1 only for lui.
REQ-022 SHALL drive these MEM outputs: IorD=1; MemRead=1 for lw; MemWrite=1 for sw.
REQ-023 SHALL drive these WB outputs:
- RegWrite=1.
- RegDst=01 for R-type, 00 for I-type.
- MemtoReg=01 for lw, 00 otherwise.
REQ-024 SHALL produce outputs combinationally from State, OpCode and Funct; every output not listed for a state SHALL be 0.
REQ-025 SHALL make ALUOp depend only on OpCode: 0 add, 1 sub (beq), 2 R-type (use Funct), 3 and, 4 or, 5 slt.

Reset
REQ-026 While reset=0, State SHALL equal IF and all write enables (PCWrite, PCWriteCond, MemWrite, IRWrite, RegWrite) SHALL be 0.
REQ-027 Reset asserted mid-instruction SHALL abort the instruction immediately, with no partial write after assertion.
REQ-028 After deassertion, the first rising edge SHALL execute IF.

Configuration
REQ-029 Macro MCTRL_MEM_WAIT_EN, when defined: IF and MEM-lw/sw SHALL hold state and outputs while MemReady=0; PCWrite and IRWrite in IF SHALL assert only in the cycle where MemReady=1.
REQ-030 When MCTRL_MEM_WAIT_EN is undefined, MemReady SHALL be ignored and the latencies in REQ-018 are exact.

Verification
REQ-031 Hold reset=0 3 cycles, then release with OpCode=0x23 -> State sequence 0,1,2,3,4,0; MemRead=1 in MEM; RegWrite=1 and MemtoReg=01 in WB.
REQ-032 OpCode=0x00, Funct=0x20 -> State 0,1,2,4,0; RegDst=01 in WB; ALUOp=2 in EX.
REQ-033 OpCode=0x04 -> State 0,1,2,0; PCWriteCond=1 and PCSource=01 in EX; ALUOp=1.
REQ-034 OpCode=0x03 -> State 0,1,0; in ID, PCWrite=1, RegWrite=1, RegDst=10.
REQ-035 OpCode=0x3f -> State 0,1,0 with no write enable asserted in ID; assert reset=0 while in MEM for sw -> MemWrite drops to 0 within the same cycle.
REQ-036 With MCTRL_MEM_WAIT_EN defined, MemReady=0 for 3 cycles in IF -> State stays 0 with IRWrite=0; MemReady=1 -> IRWrite=1, then State=1.
